// File: rtl/spi_controller.sv
// SPI mode-0 initiator: frames client bytes under CS, shifts MSB first, returns the
// byte received in the same transfer and honours target stall between bytes.
module spi_controller #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CS_GAP     = 2
) (
    input  logic                  sys_clock_i,
    input  logic                  sys_reset_i,
    input  logic                  tx_valid_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_last_i,
    output logic                  tx_ready_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  busy_o,
    output logic                  spi_cs_no,
    output logic                  spi_sck_o,
    output logic                  spi_sd_o,
    input  logic                  spi_sd_i,
    input  logic                  spi_stall_i
);

    localparam int unsigned GAP_CYC   = CS_GAP * CLK_DIV;
    localparam int unsigned CNT_MAX   = (GAP_CYC > CLK_DIV) ? GAP_CYC : CLK_DIV;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 2);
    localparam int unsigned HALF_LAST = 2 * DATA_WIDTH - 1;
    localparam int unsigned HALF_W    = $clog2(2 * DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STALL,
        S_SHIFT,
        S_NEXT,
        S_GAP
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [HALF_W-1:0]     r_half;
    logic [DATA_WIDTH-1:0] r_tx_sh;
    logic [DATA_WIDTH-1:0] r_rx_sh;
    logic                  r_last;
    logic                  r_stall_meta;
    logic                  r_stall_sync;
    logic                  r_cs_n;
    logic                  r_sck;
    logic                  r_sd;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_rx_valid;
    logic [DATA_WIDTH-1:0] r_rx_data;

    state_t                w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [HALF_W-1:0]     w_half_nxt;
    logic [DATA_WIDTH-1:0] w_tx_sh_nxt;
    logic [DATA_WIDTH-1:0] w_rx_sh_nxt;
    logic                  w_last_nxt;
    logic                  w_sck_nxt;
    logic                  w_sd_nxt;
    logic                  w_rx_valid_nxt;
    logic [DATA_WIDTH-1:0] w_rx_data_nxt;
    logic                  w_accept;
    logic                  w_half_end;

    assign w_accept   = tx_valid_i && r_ready;
    assign w_half_end = (r_cnt == CNT_W'(CLK_DIV - 1));

    // State and all outputs are registered; pin values follow the next state.
    always_ff @(posedge sys_clock_i) begin
        if (sys_reset_i) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_half       <= '0;
            r_tx_sh      <= '0;
            r_rx_sh      <= '0;
            r_last       <= 1'b0;
            r_stall_meta <= 1'b0;
            r_stall_sync <= 1'b0;
            r_cs_n       <= 1'b1;
            r_sck        <= 1'b0;
            r_sd         <= 1'b0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_rx_data    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_half       <= w_half_nxt;
            r_tx_sh      <= w_tx_sh_nxt;
            r_rx_sh      <= w_rx_sh_nxt;
            r_last       <= w_last_nxt;
            r_stall_meta <= spi_stall_i;
            r_stall_sync <= r_stall_meta;
            r_cs_n       <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_GAP);
            r_sck        <= w_sck_nxt;
            r_sd         <= w_sd_nxt;
            r_ready      <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_NEXT);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_rx_valid   <= w_rx_valid_nxt;
            r_rx_data    <= w_rx_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt + CNT_W'(1);
        w_half_nxt     = r_half;
        w_tx_sh_nxt    = r_tx_sh;
        w_rx_sh_nxt    = r_rx_sh;
        w_last_nxt     = r_last;
        w_sck_nxt      = r_sck;
        w_sd_nxt       = r_sd;
        w_rx_valid_nxt = 1'b0;
        w_rx_data_nxt  = r_rx_data;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_sd_nxt  = 1'b0;
                if (w_accept) begin
                    w_tx_sh_nxt = tx_data_i;
                    w_last_nxt  = tx_last_i;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_half_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_STALL;
                end
            end
            S_STALL: begin
                // First cycle lets the synchronizer settle; afterwards wait for stall low.
                w_cnt_nxt = CNT_W'(1);
                if ((r_cnt != '0) && !r_stall_sync) begin
                    w_cnt_nxt   = '0;
                    w_half_nxt  = '0;
                    w_sd_nxt    = r_tx_sh[DATA_WIDTH-1];
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_half_end) begin
                    w_cnt_nxt  = '0;
                    w_half_nxt = r_half + HALF_W'(1);
                    if (!r_half[0]) begin
                        w_sck_nxt   = 1'b1;
                        w_rx_sh_nxt = {r_rx_sh[DATA_WIDTH-2:0], spi_sd_i};
                    end else begin
                        w_sck_nxt = 1'b0;
                        if (r_half == HALF_W'(HALF_LAST)) begin
                            w_rx_data_nxt  = r_rx_sh;
                            w_rx_valid_nxt = 1'b1;
                            w_state_nxt    = r_last ? S_GAP : S_NEXT;
                        end else begin
                            w_tx_sh_nxt = r_tx_sh << 1;
                            w_sd_nxt    = r_tx_sh[DATA_WIDTH-2];
                        end
                    end
                end
            end
            S_NEXT: begin
                w_cnt_nxt = '0;
                if (w_accept) begin
                    w_tx_sh_nxt = tx_data_i;
                    w_last_nxt  = tx_last_i;
                    w_state_nxt = S_STALL;
                end
            end
            S_GAP: begin
                if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign tx_ready_o = r_ready;
    assign rx_data_o  = r_rx_data;
    assign rx_valid_o = r_rx_valid;
    assign busy_o     = r_busy;
    assign spi_cs_no  = r_cs_n;
    assign spi_sck_o  = r_sck;
    assign spi_sd_o   = r_sd;

endmodule
